// File: rtl/axil_regtest_pkg.sv
// Shared constants for the AXI4-Lite register self-test master: FSM encoding,
// AXI response codes and error codes reported by the error log.
package axil_regtest_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWr    = 3'd1;
  localparam logic [2:0] StWresp = 3'd2;
  localparam logic [2:0] StRd    = 3'd3;
  localparam logic [2:0] StRdata = 3'd4;
  localparam logic [2:0] StNext  = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrResp    = 2'b01;
  localparam logic [1:0] ErrData    = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

endpackage

// File: rtl/axil_regtest_errlog.sv
// Saturating error counter with capture of the first error's address and code.
module axil_regtest_errlog
  import axil_regtest_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 err,
  input  logic [1:0]           code,
  input  logic [AddrWidth-1:0] addr,
  output logic [7:0]           count,
  output logic [AddrWidth-1:0] first_addr,
  output logic [1:0]           first_code
);

  logic [7:0]           count_q;
  logic [AddrWidth-1:0] first_addr_q;
  logic [1:0]           first_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= 8'd0;
      first_addr_q <= '0;
      first_code_q <= ErrNone;
    end else if (clear) begin
      count_q      <= 8'd0;
      first_addr_q <= '0;
      first_code_q <= ErrNone;
    end else if (err) begin
      if (count_q != 8'hFF) begin
        count_q <= count_q + 8'd1;
      end
      if (count_q == 8'd0) begin
        first_addr_q <= addr;
        first_code_q <= code;
      end
    end
  end

  assign count      = count_q;
  assign first_addr = first_addr_q;
  assign first_code = first_code_q;

endmodule

// File: rtl/axil_regtest_master.sv
// AXI4-Lite master that writes N vectors to a register bank, reads them back and
// reports per-run error statistics. Ordering is per-vector (mode 0) or batched (mode 1).
module axil_regtest_master
  import axil_regtest_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_VECTORS      = 4,
  parameter int unsigned C_ADDR_STRIDE      = 4,
  parameter logic [31:0] C_DATA_INC         = 32'h01010101,
  parameter int unsigned C_TIMEOUT          = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic                            mode,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [7:0]                      err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   first_err_addr,
  output logic [1:0]                      first_err_code,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam logic [15:0]   LastIdx = 16'(C_NUM_VECTORS - 1);
  localparam logic [31:0]   TmoLast = 32'(C_TIMEOUT - 1);
  localparam logic [AW-1:0] Stride  = AW'(C_ADDR_STRIDE);
  localparam logic [DW-1:0] Inc     = DW'(C_DATA_INC);

  logic [2:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic          rd_phase_q, rd_phase_d;
  logic [15:0]   idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [31:0]   tmo_q, tmo_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          pass_q, pass_d;

  logic       log_clear;
  logic       log_err;
  logic [1:0] log_code;
  logic       tmo_hit;
  logic       last_vec;
  logic       aw_left;
  logic       w_left;

  assign tmo_hit  = (tmo_q == TmoLast);
  assign last_vec = (idx_q == LastIdx);
  assign aw_left  = awvalid_q && !M_AXI_AWREADY;
  assign w_left   = wvalid_q && !M_AXI_WREADY;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    rd_phase_d = rd_phase_q;
    idx_d      = idx_q;
    base_d     = base_q;
    seed_d     = seed_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    pass_d     = pass_q;
    log_clear  = 1'b0;
    log_err    = 1'b0;
    log_code   = ErrNone;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d     = mode;
          base_d     = base_addr;
          seed_d     = seed;
          addr_d     = base_addr;
          data_d     = seed;
          idx_d      = 16'd0;
          rd_phase_d = 1'b0;
          pass_d     = 1'b0;
          log_clear  = 1'b1;
          tmo_d      = 32'd0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          state_d    = StWr;
        end
      end
      StWr: begin
        // AW and W complete independently; move on once neither is still pending.
        if (!aw_left && !w_left) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b1;
          tmo_d     = 32'd0;
          state_d   = StWresp;
        end else if (tmo_hit) begin
          log_err   = 1'b1;
          log_code  = ErrTimeout;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          state_d   = StNext;
        end else begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
          if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
          tmo_d = tmo_q + 32'd1;
        end
      end
      StWresp: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (M_AXI_BRESP != RESP_OKAY) begin
            log_err  = 1'b1;
            log_code = ErrResp;
          end
          if (mode_q) begin
            state_d = StNext;
          end else begin
            arvalid_d = 1'b1;
            tmo_d     = 32'd0;
            state_d   = StRd;
          end
        end else if (tmo_hit) begin
          log_err  = 1'b1;
          log_code = ErrTimeout;
          bready_d = 1'b0;
          state_d  = StNext;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StRd: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = 32'd0;
          state_d   = StRdata;
        end else if (tmo_hit) begin
          log_err   = 1'b1;
          log_code  = ErrTimeout;
          arvalid_d = 1'b0;
          state_d   = StNext;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StRdata: begin
        if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (M_AXI_RRESP != RESP_OKAY) begin
            log_err  = 1'b1;
            log_code = ErrResp;
          end else if (M_AXI_RDATA != data_q) begin
            log_err  = 1'b1;
            log_code = ErrData;
          end
          state_d = StNext;
        end else if (tmo_hit) begin
          log_err  = 1'b1;
          log_code = ErrTimeout;
          rready_d = 1'b0;
          state_d  = StNext;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StNext: begin
        tmo_d = 32'd0;
        if (mode_q && !rd_phase_q && last_vec) begin
          // Batched mode: all writes issued, restart the walk for the read pass.
          rd_phase_d = 1'b1;
          idx_d      = 16'd0;
          addr_d     = base_q;
          data_d     = seed_q;
          arvalid_d  = 1'b1;
          state_d    = StRd;
        end else if (last_vec) begin
          pass_d  = (err_count == 8'd0);
          state_d = StDone;
        end else begin
          idx_d  = idx_q + 16'd1;
          addr_d = addr_q + Stride;
          data_d = data_q + Inc;
          if (mode_q && rd_phase_q) begin
            arvalid_d = 1'b1;
            state_d   = StRd;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      rd_phase_q <= 1'b0;
      idx_q      <= 16'd0;
      base_q     <= '0;
      seed_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tmo_q      <= 32'd0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      rd_phase_q <= rd_phase_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      seed_q     <= seed_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      pass_q     <= pass_d;
    end
  end

  axil_regtest_errlog #(
    .AddrWidth(AW)
  ) u_errlog (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .clear      (log_clear),
    .err        (log_err),
    .code       (log_code),
    .addr       (addr_q),
    .count      (err_count),
    .first_addr (first_err_addr),
    .first_code (first_err_code)
  );

  assign busy = (state_q != StIdle) && (state_q != StDone);
  assign done = (state_q == StDone);
  assign pass = pass_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = data_q;
  assign M_AXI_WSTRB   = {(DW/8){1'b1}};
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_regtest_master.sv
// Scoreboard bench: expected writes, read addresses and run results are queued when a
// run is issued; slave-side and done-side monitors pop and compare as the DUT presents them.
module tb_axil_regtest_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Main DUT signals
  logic        start, mode, busy, done, pass;
  logic [31:0] base_addr, seed, first_err_addr;
  logic [7:0]  err_count;
  logic [1:0]  first_err_code;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_regtest_master u_dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_code(first_err_code),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Saturation DUT: many vectors against a slave that always returns inverted data
  logic        start2, busy2, done2, pass2;
  logic [31:0] first_err_addr2;
  logic [7:0]  err_count2;
  logic [1:0]  first_err_code2;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, s_last;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;

  axil_regtest_master #(.C_NUM_VECTORS(260), .C_TIMEOUT(64)) u_sat (
    .ACLK(clk), .ARESETN(rst_n), .start(start2), .mode(1'b0), .base_addr(32'h1000),
    .seed(32'h0), .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_addr(first_err_addr2), .first_err_code(first_err_code2),
    .M_AXI_AWADDR(s_awaddr), .M_AXI_AWPROT(s_awprot), .M_AXI_AWVALID(s_awvalid),
    .M_AXI_AWREADY(s_awready), .M_AXI_WDATA(s_wdata), .M_AXI_WSTRB(s_wstrb),
    .M_AXI_WVALID(s_wvalid), .M_AXI_WREADY(s_wready), .M_AXI_BRESP(s_bresp),
    .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(s_bready), .M_AXI_ARADDR(s_araddr),
    .M_AXI_ARPROT(s_arprot), .M_AXI_ARVALID(s_arvalid), .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid),
    .M_AXI_RREADY(s_rready)
  );

  assign s_awready = s_awvalid && s_wvalid;
  assign s_wready  = s_awvalid && s_wvalid;
  assign s_arready = s_arvalid;
  assign s_bresp   = 2'b00;
  assign s_rresp   = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= 32'h0;
      s_last   <= 32'h0;
    end else begin
      if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      if (s_awvalid && s_wvalid) begin
        s_bvalid <= 1'b1;
        s_last   <= s_wdata;
      end
      if (s_rvalid && s_rready) s_rvalid <= 1'b0;
      if (s_arvalid) begin
        s_rvalid <= 1'b1;
        s_rdata  <= ~s_last;
      end
    end
  end

  // Scoreboard queues
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  skew;
  } wr_t;
  typedef struct packed {
    logic        pass;
    logic [7:0]  cnt;
    logic [31:0] faddr;
    logic [1:0]  fcode;
  } res_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_ar[$];
  res_t        exp_res[$];
  res_t        exp_sat[$];
  wr_t         mon_w;
  res_t        mon_r;
  res_t        mon_s;

  // Slave knobs
  int          aw_delay = 0;
  int          w_delay = 0;
  logic        berr_en = 1'b0;
  logic [31:0] berr_addr = 32'h0;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;
  logic        hang_en = 1'b0;
  logic [31:0] hang_addr = 32'h0;
  logic        order_check = 1'b0;
  int          wr_base = 0;

  logic [31:0] mem [256];
  int          aw_wait, w_wait, aw_cyc, w_cyc, last_ar_cyc;
  int          wr_done_cnt = 0;
  logic        wa_have, wd_have;
  logic [31:0] wa_q, wd_q;

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid && (w_wait >= w_delay);
  assign arready = arvalid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0;
      w_wait  <= 0;
      wa_have <= 1'b0;
      wd_have <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      rvalid  <= 1'b0;
      rresp   <= 2'b00;
      rdata   <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      if (awvalid && awready) begin
        aw_wait <= 0;
        wa_have <= 1'b1;
        wa_q    <= awaddr;
        aw_cyc  <= cyc;
        chk("awprot", awprot, 3'b000);
      end
      if (wvalid && !wready) w_wait <= w_wait + 1;
      if (wvalid && wready) begin
        w_wait  <= 0;
        wd_have <= 1'b1;
        wd_q    <= wdata;
        w_cyc   <= cyc;
        chk("wstrb", wstrb, 4'hF);
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (wa_have && wd_have && !bvalid) begin
        mem[wa_q[9:2]] <= wd_q;
        bresp          <= (berr_en && wa_q == berr_addr) ? 2'b10 : 2'b00;
        bvalid         <= 1'b1;
        wa_have        <= 1'b0;
        wd_have        <= 1'b0;
        wr_done_cnt    <= wr_done_cnt + 1;
        chk("wr_expected", exp_wr.size() != 0, 1'b1);
        if (exp_wr.size() != 0) begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", wa_q, mon_w.addr);
          chk("wr_data", wd_q, mon_w.data);
          chk("wr_aw_after_w_cycles", aw_cyc - w_cyc, mon_w.skew);
        end
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        last_ar_cyc <= cyc;
        chk("ar_expected", exp_ar.size() != 0, 1'b1);
        if (exp_ar.size() != 0) chk("ar_addr", araddr, exp_ar.pop_front());
        chk("arprot", arprot, 3'b000);
        if (order_check) chk("ar_after_all_writes", wr_done_cnt - wr_base, 4);
        if (!(hang_en && araddr == hang_addr)) begin
          rvalid <= 1'b1;
          rresp  <= 2'b00;
          rdata  <= mem[araddr[9:2]] ^ ((corrupt_en && araddr == corrupt_addr) ? 32'h1 : 32'h0);
        end
      end
    end
  end

  // Result monitors
  int done_cnt = 0;
  int done_cyc = 0;
  int sat_cnt = 0;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("res_expected", exp_res.size() != 0, 1'b1);
      if (exp_res.size() != 0) begin
        mon_r = exp_res.pop_front();
        chk("pass", pass, mon_r.pass);
        chk("err_count", err_count, mon_r.cnt);
        chk("first_err_addr", first_err_addr, mon_r.faddr);
        chk("first_err_code", first_err_code, mon_r.fcode);
        chk("busy_low_at_done", busy, 1'b0);
      end
    end
    if (done2) begin
      sat_cnt++;
      chk("sat_expected", exp_sat.size() != 0, 1'b1);
      if (exp_sat.size() != 0) begin
        mon_s = exp_sat.pop_front();
        chk("sat_pass", pass2, mon_s.pass);
        chk("sat_err_count", err_count2, mon_s.cnt);
        chk("sat_first_err_addr", first_err_addr2, mon_s.faddr);
        chk("sat_first_err_code", first_err_code2, mon_s.fcode);
      end
    end
  end

  task automatic vec(input logic [31:0] a, input logic [31:0] d, input logic [7:0] sk);
    exp_wr.push_back('{addr: a, data: d, skew: sk});
    exp_ar.push_back(a);
  endtask

  task automatic res(input logic p, input logic [7:0] c, input logic [31:0] fa,
                     input logic [1:0] fc);
    exp_res.push_back('{pass: p, cnt: c, faddr: fa, fcode: fc});
  endtask

  task automatic run(input logic m, input logic [31:0] b, input logic [31:0] s,
                     input int budget, input logic poke_busy, input logic poke_done);
    logic seen;
    seen    = 1'b0;
    wr_base = wr_done_cnt;
    mode      = m;
    base_addr = b;
    seed      = s;
    start     = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (poke_busy && i == 10) begin
        chk("busy_mid_run", busy, 1'b1);
        base_addr = 32'h800;
        seed      = 32'h0;
        start     = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        if (poke_done) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          #1;
          chk("start_at_done_ignored", busy, 1'b0);
        end
        break;
      end
    end
    chk("run_finished", seen, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    start     = 1'b0;
    start2    = 1'b0;
    mode      = 1'b0;
    base_addr = 32'h0;
    seed      = 32'h0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_first_err_addr", first_err_addr, 32'h0);
    chk("rst_first_err_code", first_err_code, 2'b00);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);

    // 1: mode 0, zero-wait; data_i = seed + i*0x01010101 with carries rippling across bytes
    vec(32'h0, 32'h0101FFFF, 8'd0);
    vec(32'h4, 32'h02030100, 8'd0);
    vec(32'h8, 32'h03040201, 8'd0);
    vec(32'hC, 32'h04050302, 8'd0);
    res(1'b1, 8'd0, 32'h0, 2'b00);
    run(1'b0, 32'h0, 32'h0101FFFF, 300, 1'b0, 1'b1);

    // 2: mode 1, AWREADY held off 3 cycles; start pulse mid-run must be ignored
    aw_delay    = 3;
    order_check = 1'b1;
    vec(32'h40, 32'h11223344, 8'd3);
    vec(32'h44, 32'h12233445, 8'd3);
    vec(32'h48, 32'h13243546, 8'd3);
    vec(32'h4C, 32'h14253647, 8'd3);
    res(1'b1, 8'd0, 32'h0, 2'b00);
    run(1'b1, 32'h40, 32'h11223344, 400, 1'b1, 1'b0);
    aw_delay    = 0;
    order_check = 1'b0;

    // 3: read of 0x8 corrupted in bit 0
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h8;
    vec(32'h0, 32'h00000000, 8'd0);
    vec(32'h4, 32'h01010101, 8'd0);
    vec(32'h8, 32'h02020202, 8'd0);
    vec(32'hC, 32'h03030303, 8'd0);
    res(1'b0, 8'd1, 32'h8, 2'b10);
    run(1'b0, 32'h0, 32'h0, 300, 1'b0, 1'b0);
    corrupt_en = 1'b0;

    // 4: SLVERR on write 0x4, read of 0xC never answered
    berr_en   = 1'b1;
    berr_addr = 32'h4;
    hang_en   = 1'b1;
    hang_addr = 32'hC;
    vec(32'h0, 32'hA5A5A5A5, 8'd0);
    vec(32'h4, 32'hA6A6A6A6, 8'd0);
    vec(32'h8, 32'hA7A7A7A7, 8'd0);
    vec(32'hC, 32'hA8A8A8A8, 8'd0);
    res(1'b0, 8'd2, 32'h4, 2'b01);
    run(1'b0, 32'h0, 32'hA5A5A5A5, 1500, 1'b0, 1'b0);
    chk("timeout_window", (done_cyc - last_ar_cyc >= 1024) && (done_cyc - last_ar_cyc <= 1040),
        1'b1);
    berr_en = 1'b0;
    hang_en = 1'b0;

    // 5a: 260 vectors, every read mismatches; count saturates
    exp_sat.push_back('{pass: 1'b0, cnt: 8'd255, faddr: 32'h1000, fcode: 2'b10});
    begin
      int n0;
      n0     = sat_cnt;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 5000 && sat_cnt == n0; i++) @(negedge clk);
      chk("sat_run_finished", sat_cnt != n0, 1'b1);
    end

    // 5b: address wrap past 2^32, batched mode
    order_check = 1'b1;
    vec(32'hFFFFFFF8, 32'hFFFFFFFE, 8'd0);
    vec(32'hFFFFFFFC, 32'h010100FF, 8'd0);
    vec(32'h00000000, 32'h02020200, 8'd0);
    vec(32'h00000004, 32'h03030301, 8'd0);
    res(1'b1, 8'd0, 32'h0, 2'b00);
    run(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFE, 400, 1'b0, 1'b0);
    order_check = 1'b0;

    // 6: reset while AWVALID is high
    aw_delay  = 3;
    mode      = 1'b0;
    base_addr = 32'h200;
    seed      = 32'h5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (awvalid) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("awvalid_seen_before_reset", hit, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_pass", pass, 1'b0);
    chk("midrst_err_count", err_count, 8'd0);
    chk("midrst_first_err", {first_err_addr, first_err_code}, 34'h0);
    chk("midrst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    aw_delay = 0;
    @(negedge clk);

    // 6b: clean run after reset
    vec(32'h100, 32'h00000010, 8'd0);
    vec(32'h104, 32'h01010111, 8'd0);
    vec(32'h108, 32'h02020212, 8'd0);
    vec(32'h10C, 32'h03030313, 8'd0);
    res(1'b1, 8'd0, 32'h0, 2'b00);
    run(1'b0, 32'h100, 32'h10, 300, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("ar_queue_drained", exp_ar.size(), 0);
    chk("res_queue_drained", exp_res.size(), 0);
    chk("sat_queue_drained", exp_sat.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
